hrange_stream: RTL and testbench
================================

Name: hrange_stream

Overview:
- Parametrised range generator. Streams the signed sequence base, base+step, base+2*step, ... while the value is inside the limit.
- Supports positive and negative step, an inclusive-limit mode, overflow-safe termination and consumer backpressure via _wait.
- Used as a leaf producer feeding function-call/generator consumers in the generated-hardware flow.
- One value per cycle when not stalled; registered outputs throughout.

Parameters:
- WIDTH, 32: data width of base/limit/step/_0, two's-complement signed.
- INCL_EN, 1: 1 = the inclusive input is honoured; 0 = inclusive is ignored and treated as 0.

Ports:
- _clock  in  1  rising-edge clock.
- _reset  in  1  asynchronous, active-high reset.
- _start  in  1  one-cycle pulse; captures base/limit/step/inclusive and (re)starts the sequence.
- base  in  WIDTH  signed first value.
- limit  in  WIDTH  signed bound.
- step  in  WIDTH  signed increment.
- inclusive  in  1  1 = the limit value itself is emitted if reached exactly.
- _wait  in  1  consumer stall; a transfer occurs only on a cycle with _valid=1 and _wait=0.
- _0  out  WIDTH  current sequence value; meaningful only while _valid=1.
- _valid  out  1  _0 holds a value.
- _ready  out  1  one-cycle pulse: sequence exhausted, block idle.
- _busy  out  1  high from the cycle after an accepted _start until the cycle _ready pulses.

Behaviour:
- Reset (async assert, released synchronously by the clock domain): state=IDLE; _0=0, _valid=0, _ready=0, _busy=0; internal registers cleared.
- In-range test, in(v):
  - step>0: v<limit, or v<=limit when inclusive.
  - step<0: v>limit, or v>=limit when inclusive.
  - step==0: always false, so the sequence is empty. No infinite streams.
- Next-value arithmetic: nxt = cur+step, computed at WIDTH+1 bits. If the result overflows the signed WIDTH range, the sequence ends. It never wraps.
- States: IDLE, EMIT.
- _start seen at edge N, in any state (takes precedence over current activity; abort-and-restart):
  - latch base/limit/step/inclusive; cur <= base.
  - if in(base): at N+1, _0=base, _valid=1, _busy=1, state EMIT.
  - else: at N+1, _ready=1, _valid=0, _busy=0, state IDLE.
- EMIT, edge with _wait=1: _0, _valid and cur are held unchanged (stall). No value is ever dropped or duplicated.
- EMIT, edge with _wait=0 (transfer):
  - if nxt did not overflow and in(nxt): _0 <= nxt, cur <= nxt, _valid stays 1.
  - else: _valid <= 0, _ready <= 1 for one cycle, _busy <= 0, state IDLE.
- IDLE with no _start: _valid=0, _busy=0, _ready=0 except for the single completion pulse.
- _ready and _valid are never high in the same cycle.
- Sequence length: ceil((limit-base)/step), or one more in inclusive mode when the limit is hit exactly. Throughput is one value per cycle with _wait=0.
- Latency: _start to first _valid is 1 cycle. Last transfer to _ready is 1 cycle.
- _reset asserted mid-sequence: immediate return to reset values; no _ready pulse.
- _reset and _start asserted together: _reset wins.
- Input ports are sampled only on the _start edge; later changes have no effect.

Decomposition:
- Package hrange_pkg holds:
  - the state enum (IDLE, EMIT);
  - the default WIDTH constant;
  - a function computing the signed add with an overflow flag.
- Sub-module hrange_step_cmp (combinational): inputs cur, step, limit, inclusive; outputs nxt, nxt_ok (= no overflow and in(nxt)) and base_ok.
- Top level holds only the FSM and output registers.

Test Plan:
- base=0, limit=5, step=1, inclusive=0, _wait=0 -> _0 = 0,1,2,3,4 on consecutive cycles starting N+1; _ready pulses at N+6; _busy high N+1..N+5.
- base=10, limit=0, step=-3, inclusive=1 -> 10,7,4,1 then _ready. Repeat with limit=1, inclusive=1 -> 10,7,4,1 (limit hit exactly and emitted); with inclusive=0 -> 10,7,4 only.
- base=0, limit=4, step=1, _wait high for 3 cycles while _0=2 -> _0 held at 2 with _valid=1 throughout the stall; full sequence 0,1,2,3 with no loss or duplicate.
- Empty/degenerate ranges:
  - base=5, limit=5, step=1, inclusive=0 -> no _valid; _ready at N+1.
  - step=0 -> same result.
- WIDTH=8, base=120, limit=127, step=5, inclusive=1 -> 120,125, then 130 overflows -> _ready. No wrap to -126.
- Mid-sequence _start (new base=100, limit=102, step=1) -> next cycle _0=100, no _ready pulse for the aborted run. Async _reset mid-sequence -> _valid=0 and _0=0 before the next clock edge.

Source files
------------

// File: rtl/hrange_pkg.sv
// Shared types and arithmetic helpers for the range stream generator.
package hrange_pkg;

    localparam int DEFAULT_WIDTH = 32;
    // Widest data path the overflow helper supports.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [0:0] {
        IDLE,
        EMIT
    } state_t;

    typedef struct packed {
        logic                 ovf;
        logic [MAX_WIDTH-1:0] sum;
    } add_res_t;

    // Adds two sign-extended operands one bit wider than MAX_WIDTH, so the
    // sum is always exact, then flags results outside the signed range of
    // 'width' bits.
    function automatic add_res_t add_ovf(
        input logic signed [MAX_WIDTH-1:0] a,
        input logic signed [MAX_WIDTH-1:0] b,
        input int                          width
    );
        logic signed [MAX_WIDTH:0] full;
        logic signed [MAX_WIDTH:0] one;
        logic signed [MAX_WIDTH:0] hi;
        logic signed [MAX_WIDTH:0] lo;
        add_res_t                  res;
        one    = '0;
        one[0] = 1'b1;
        full   = {a[MAX_WIDTH-1], a} + {b[MAX_WIDTH-1], b};
        hi     = (one <<< (width - 1)) - one;
        lo     = -hi - one;
        res.ovf = (full > hi) || (full < lo);
        res.sum = full[MAX_WIDTH-1:0];
        return res;
    endfunction

endpackage

// File: rtl/hrange_if.sv
// Control and data stream between a range generator and its consumer.
interface hrange_if #(
    parameter int WIDTH = hrange_pkg::DEFAULT_WIDTH
);
    logic                    _start;
    logic signed [WIDTH-1:0] base;
    logic signed [WIDTH-1:0] limit;
    logic signed [WIDTH-1:0] step;
    logic                    inclusive;
    logic                    _wait;
    logic signed [WIDTH-1:0] _0;
    logic                    _valid;
    logic                    _ready;
    logic                    _busy;

    // Consumer / controller side.
    modport master (
        output _start, base, limit, step, inclusive, _wait,
        input  _0, _valid, _ready, _busy
    );

    // Generator side.
    modport slave (
        input  _start, base, limit, step, inclusive, _wait,
        output _0, _valid, _ready, _busy
    );
endinterface

// File: rtl/hrange_step_cmp.sv
// Next-value arithmetic and in-range tests. base_ok is the range test of
// cur itself; the top feeds the incoming base through cur on a start cycle.
module hrange_step_cmp
    import hrange_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic signed [WIDTH-1:0] cur,
    input  logic signed [WIDTH-1:0] step,
    input  logic signed [WIDTH-1:0] limit,
    input  logic                    inclusive,
    output logic signed [WIDTH-1:0] nxt,
    output logic                    nxt_ok,
    output logic                    base_ok
);

    // Zero step is never in range, so a zero-step sequence is always empty.
    function automatic logic in_range(
        input logic signed [MAX_WIDTH-1:0] v,
        input logic signed [MAX_WIDTH-1:0] s,
        input logic signed [MAX_WIDTH-1:0] lim,
        input logic                        incl
    );
        if (s > 0) begin
            return incl ? (v <= lim) : (v < lim);
        end else if (s < 0) begin
            return incl ? (v >= lim) : (v > lim);
        end
        return 1'b0;
    endfunction

    logic signed [MAX_WIDTH-1:0] cur_x;
    logic signed [MAX_WIDTH-1:0] step_x;
    logic signed [MAX_WIDTH-1:0] limit_x;
    logic signed [MAX_WIDTH-1:0] sum_x;
    add_res_t                    sum_res;

    // Widen operands, add exactly, and test the wide sum so overflow never wraps into range.
    always_comb begin
        cur_x   = MAX_WIDTH'(cur);
        step_x  = MAX_WIDTH'(step);
        limit_x = MAX_WIDTH'(limit);
        sum_res = add_ovf(cur_x, step_x, WIDTH);
        sum_x   = sum_res.sum;
        nxt     = sum_x[WIDTH-1:0];
        nxt_ok  = !sum_res.ovf && in_range(sum_x, step_x, limit_x, inclusive);
        base_ok = in_range(cur_x, step_x, limit_x, inclusive);
    end

endmodule

// File: rtl/hrange_stream.sv
// Range generator: streams base, base+step, ... while inside limit.
// One value per cycle when not stalled; all outputs are registered.
module hrange_stream
    import hrange_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int INCL_EN = 1
) (
    input logic    _clock,
    input logic    _reset,
    hrange_if.slave bus
);

    state_t                  state, state_nx;
    logic signed [WIDTH-1:0] cur, cur_nx;
    logic signed [WIDTH-1:0] step_r, step_nx;
    logic signed [WIDTH-1:0] limit_r, limit_nx;
    logic                    incl_r, incl_nx;
    logic                    valid, valid_nx;
    logic                    ready, ready_nx;
    logic                    busy, busy_nx;

    logic                    incl_in;
    logic signed [WIDTH-1:0] cmp_cur;
    logic signed [WIDTH-1:0] cmp_step;
    logic signed [WIDTH-1:0] cmp_limit;
    logic                    cmp_incl;
    logic signed [WIDTH-1:0] nxt;
    logic                    nxt_ok;
    logic                    base_ok;

    assign incl_in = (INCL_EN != 0) ? bus.inclusive : 1'b0;

    // On a start cycle the comparator judges the incoming base; otherwise it steps the latched run.
    assign cmp_cur   = bus._start ? bus.base  : cur;
    assign cmp_step  = bus._start ? bus.step  : step_r;
    assign cmp_limit = bus._start ? bus.limit : limit_r;
    assign cmp_incl  = bus._start ? incl_in   : incl_r;

    hrange_step_cmp #(.WIDTH(WIDTH)) u_step_cmp (
        .cur       (cmp_cur),
        .step      (cmp_step),
        .limit     (cmp_limit),
        .inclusive (cmp_incl),
        .nxt       (nxt),
        .nxt_ok    (nxt_ok),
        .base_ok   (base_ok)
    );

    // Next-state and output decisions; a start always aborts and restarts.
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        step_nx  = step_r;
        limit_nx = limit_r;
        incl_nx  = incl_r;
        valid_nx = valid;
        busy_nx  = busy;
        ready_nx = 1'b0;
        if (bus._start) begin
            cur_nx   = bus.base;
            step_nx  = bus.step;
            limit_nx = bus.limit;
            incl_nx  = incl_in;
            if (base_ok) begin
                state_nx = EMIT;
                valid_nx = 1'b1;
                busy_nx  = 1'b1;
            end else begin
                state_nx = IDLE;
                valid_nx = 1'b0;
                busy_nx  = 1'b0;
                ready_nx = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    valid_nx = 1'b0;
                    busy_nx  = 1'b0;
                end
                EMIT: begin
                    if (!bus._wait) begin
                        if (nxt_ok) begin
                            cur_nx = nxt;
                        end else begin
                            state_nx = IDLE;
                            valid_nx = 1'b0;
                            busy_nx  = 1'b0;
                            ready_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state   <= IDLE;
            cur     <= '0;
            step_r  <= '0;
            limit_r <= '0;
            incl_r  <= 1'b0;
            valid   <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cur     <= cur_nx;
            step_r  <= step_nx;
            limit_r <= limit_nx;
            incl_r  <= incl_nx;
            valid   <= valid_nx;
            ready   <= ready_nx;
            busy    <= busy_nx;
        end
    end

    assign bus._0     = cur;
    assign bus._valid = valid;
    assign bus._ready = ready;
    assign bus._busy  = busy;

endmodule

// File: tb/tb_hrange_stream.sv
// Bench for hrange_stream (8-bit data path). A queue holds the values still
// owed for the current run, generated from the range rules with plain
// integer arithmetic; the DUT is compared against it every cycle.
module tb_hrange_stream;
    localparam int     W    = 8;
    localparam longint VMAX = 127;
    localparam longint VMIN = -128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hrange_if #(.WIDTH(W)) bus ();

    hrange_stream #(.WIDTH(W), .INCL_EN(1)) dut (
        ._clock (clk),
        ._reset (rst),
        .bus    (bus.slave)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_q[$];
    bit     exp_ready;
    bit     rst_clean;
    longint got_q[$];
    int     cyc;
    int     ready_at;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input longint v, input longint l, input longint s, input bit inc);
        if (s > 0) return inc ? (v <= l) : (v < l);
        if (s < 0) return inc ? (v >= l) : (v > l);
        return 1'b0;
    endfunction

    task automatic build_seq(input longint b, input longint l, input longint s, input bit inc);
        longint v;
        exp_q.delete();
        v = b;
        while (in_rng(v, l, s, inc)) begin
            exp_q.push_back(v);
            v = v + s;
            if (v > VMAX || v < VMIN) break;
        end
    endtask

    task automatic check_outputs();
        check_val("valid", bus._valid, longint'(exp_q.size() > 0));
        check_val("busy", bus._busy, longint'(exp_q.size() > 0));
        check_val("ready", bus._ready, longint'(exp_ready));
        if (exp_q.size() > 0) check_val("data", bus._0, exp_q[0]);
        else if (rst_clean) check_val("data_rst", bus._0, 0);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input bit st, input longint b, input longint l, input longint s,
                         input bit inc, input bit w);
        bit     pre_valid;
        longint pre_val;
        pre_valid = bus._valid;
        pre_val   = bus._0;
        bus._start = st;
        bus._wait  = w;
        if (st) begin
            bus.base      = W'(b);
            bus.limit     = W'(l);
            bus.step      = W'(s);
            bus.inclusive = inc;
        end else begin
            bus.base      = W'($urandom);
            bus.limit     = W'($urandom);
            bus.step      = W'($urandom);
            bus.inclusive = 1'($urandom);
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_ready = 1'b0;
            rst_clean = 1'b1;
        end else if (st) begin
            build_seq(b, l, s, inc);
            exp_ready = (exp_q.size() == 0);
            rst_clean = 1'b0;
            got_q.delete();
            cyc      = 1;
            ready_at = -1;
        end else begin
            cyc++;
            exp_ready = 1'b0;
            if (pre_valid && !w) got_q.push_back(pre_val);
            if (exp_q.size() > 0 && !w) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_ready = 1'b1;
            end
        end
        #1;
        check_outputs();
        if (bus._ready) ready_at = cyc;
        @(negedge clk);
        bus._start = 1'b0;
    endtask

    task automatic idle(input int n, input bit w);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 1'b0, w);
    endtask

    task automatic check_seq(input string tag, input int n, input longint first, input longint stp);
        check_val({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < n; i++)
            check_val({tag, "_val"}, got_q[i], first + longint'(i) * stp);
    endtask

    // Reset asserted between clock edges, held over one edge together with a start.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check_val("arst_valid", bus._valid, 0);
        check_val("arst_data", bus._0, 0);
        check_val("arst_busy", bus._busy, 0);
        check_val("arst_ready", bus._ready, 0);
        exp_q.delete();
        exp_ready = 1'b0;
        rst_clean = 1'b1;
        @(negedge clk);
        cycle(1'b1, 7, 20, 1, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        longint b, l, s;
        bit     inc;
        rst           = 1'b1;
        bus._start    = 1'b0;
        bus._wait     = 1'b0;
        bus.base      = '0;
        bus.limit     = '0;
        bus.step      = '0;
        bus.inclusive = 1'b0;
        exp_ready     = 1'b0;
        rst_clean     = 1'b1;
        cyc           = 0;
        ready_at      = -1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 0, 5, 1, 1'b0, 1'b0);
        idle(7, 1'b0);
        check_seq("up5", 5, 0, 1);
        check_val("up5_ready_at", ready_at, 6);

        cycle(1'b1, 10, 0, -3, 1'b1, 1'b0);
        idle(6, 1'b0);
        check_seq("down_l0", 4, 10, -3);
        cycle(1'b1, 10, 1, -3, 1'b1, 1'b0);
        idle(6, 1'b0);
        check_seq("down_l1_incl", 4, 10, -3);
        cycle(1'b1, 10, 1, -3, 1'b0, 1'b0);
        idle(6, 1'b0);
        check_seq("down_l1_excl", 3, 10, -3);

        cycle(1'b1, 0, 4, 1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        check_val("stall_hold", bus._0, 2);
        idle(5, 1'b0);
        check_seq("stall", 4, 0, 1);

        cycle(1'b1, 5, 5, 1, 1'b0, 1'b0);
        idle(2, 1'b0);
        check_val("empty_ready_at", ready_at, 1);
        check_seq("empty", 0, 0, 0);
        cycle(1'b1, 5, 100, 0, 1'b1, 1'b0);
        idle(2, 1'b0);
        check_val("zstep_ready_at", ready_at, 1);

        cycle(1'b1, 120, 127, 5, 1'b1, 1'b0);
        idle(4, 1'b0);
        check_seq("ovf", 2, 120, 5);
        check_val("ovf_ready_at", ready_at, 3);

        cycle(1'b1, 0, 50, 1, 1'b0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b1, 100, 102, 1, 1'b0, 1'b0);
        check_val("abort_first", bus._0, 100);
        idle(4, 1'b0);
        check_seq("abort", 2, 100, 1);
        check_val("abort_ready_at", ready_at, 3);

        cycle(1'b1, 0, 50, 1, 1'b0, 1'b0);
        idle(3, 1'b0);
        async_reset();
        idle(3, 1'b0);

        for (int it = 0; it < 300; it++) begin
            b   = longint'($urandom_range(0, 255)) - 128;
            l   = longint'($urandom_range(0, 255)) - 128;
            inc = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       s = 0;
                1:       s = longint'($urandom_range(0, 255)) - 128;
                default: s = ($urandom_range(0, 1) != 0) ? longint'($urandom_range(1, 12))
                                                         : -longint'($urandom_range(1, 12));
            endcase
            cycle(1'b1, b, l, s, inc, 1'b0);
            for (int k = 0; k < 800 && exp_q.size() > 0; k++) begin
                if ($urandom_range(0, 39) == 0) begin
                    b = longint'($urandom_range(0, 255)) - 128;
                    l = longint'($urandom_range(0, 255)) - 128;
                    s = longint'($urandom_range(0, 16)) - 8;
                    cycle(1'b1, b, l, s, 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    cycle(1'b0, 0, 0, 0, 1'b0, ($urandom_range(0, 3) == 0));
                end
            end
            if (exp_q.size() > 0) check_val("rand_timeout", exp_q.size(), 0);
            idle(1, 1'($urandom_range(0, 1)));
            if (it % 50 == 49) begin
                cycle(1'b1, -100, 100, 3, 1'b0, 1'b0);
                idle(2, 1'b0);
                async_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
